pp_loop_ctrl: RTL and testbench

- Sequencer for one HLS pipelined loop. Produces the pre-loop, iteration-start/end, drain and post-loop sequencing that the pipelined-loop monitor interface observes.
- Issues one iteration every II cycles up to a latched trip count and tracks in-flight iterations through a DEPTH-stage valid pipeline.
- Honours a global stall and an early-quit request, then pulses finish.
- Sits between the kernel top-level start/done logic and the loop datapath.

---
 rtl/pp_loop_pkg.sv | 25 ++
 rtl/pp_loop_ctrl_valid_pipe.sv | 45 ++++
 rtl/pp_loop_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pp_loop_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_loop_pkg.sv
// -----------------------------------------------------------------------------
// pp_loop_pkg
// Shared types for the pipelined-loop sequencer.
//   loop_state_e    : controller state encoding. The numeric values are fixed
//                     because the loop monitor decodes cur_state directly.
//   LOOP_STATE_W    : width of loop_state_e.
//   inflight_w()    : counter width able to hold 0..depth in-flight iterations.
// -----------------------------------------------------------------------------
package pp_loop_pkg;

    localparam int LOOP_STATE_W = 3;

    typedef enum logic [LOOP_STATE_W-1:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        LOOP  = 3'd2,
        DRAIN = 3'd3,
        POST  = 3'd4
    } loop_state_e;

    function automatic int inflight_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pp_loop_ctrl_valid_pipe.sv
// -----------------------------------------------------------------------------
// pp_valid_pipe
// Stall-gated valid shift register that tracks issued iterations until they
// retire.
//   clock   : rising-edge clock
//   reset   : synchronous active-high, empties the pipe
//   stall   : freezes the pipe and suppresses end_en
//   issue   : an iteration is issued this cycle (stage 0 of the pipe)
//   end_en  : the oldest tracked iteration retires this cycle
// Stage 0 is the issue strobe itself, so only DEPTH-1 stages are registered
// and the unstalled issue-to-retire latency is DEPTH-1 cycles.
// -----------------------------------------------------------------------------
module pp_valid_pipe #(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic stall,
    input  logic issue,
    output logic end_en
);

    generate
        if (DEPTH == 1) begin : g_comb
            // A single-stage loop retires in the same cycle it issues.
            assign end_en = issue & ~stall;
        end else begin : g_pipe
            logic [DEPTH-1:1] v;

            always_ff @(posedge clock) begin
                if (reset) begin
                    v <= '0;
                end else if (!stall) begin
                    v[1] <= issue;
                    for (int k = 2; k < DEPTH; k++) begin
                        v[k] <= v[k-1];
                    end
                end
            end

            assign end_en = v[DEPTH-1] & ~stall;
        end
    endgenerate

endmodule

// File: rtl/pp_loop_ctrl.sv
// -----------------------------------------------------------------------------
// pp_loop_ctrl
// Sequencer for one pipelined loop: PRE -> LOOP -> (DRAIN) -> POST -> IDLE.
// Issues one iteration every II unstalled cycles up to the latched trip count,
// tracks in-flight iterations, honours stall and quit, and pulses finish.
//   clock, reset        : rising edge, synchronous active-high reset
//   start               : begin a loop; only looked at in IDLE
//   trip_count          : iteration count, captured with start
//   stall               : freezes all loop progress in LOOP/DRAIN
//   quit                : stop issuing; in-flight iterations still drain
//   cur_state           : IDLE=0 PRE=1 LOOP=2 DRAIN=3 POST=4
//   pre/post_states_valid : high in PRE / POST
//   iter_start_enable   : iteration issued this cycle, index on iter_index
//   iter_end_enable     : iteration retires this cycle
//   quit_at_end         : loop ended by quit; held until the next start
//   finish              : one-cycle pulse in POST
//   busy                : state is not IDLE
// start is a level, not a valid/ready handshake: it is consumed only on the
// IDLE cycle it is seen, and ignored everywhere else.
// -----------------------------------------------------------------------------
module pp_loop_ctrl
    import pp_loop_pkg::*;
#(
    parameter int FSM_WIDTH = 3,
    parameter int II        = 1,
    parameter int DEPTH     = 4,
    parameter int TRIP_W    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [TRIP_W-1:0]    trip_count,
    input  logic                 stall,
    input  logic                 quit,
    output logic [FSM_WIDTH-1:0] cur_state,
    output logic                 pre_states_valid,
    output logic                 post_states_valid,
    output logic                 iter_start_enable,
    output logic [TRIP_W-1:0]    iter_index,
    output logic                 iter_end_enable,
    output logic                 quit_at_end,
    output logic                 finish,
    output logic                 busy
);

    localparam int II_W = (II > 1) ? $clog2(II) : 1;
    localparam int IF_W = inflight_w(DEPTH);

    loop_state_e       state;
    logic [TRIP_W-1:0] trip_q;
    logic [TRIP_W-1:0] issued;
    logic [II_W-1:0]   ii_cnt;
    logic [IF_W-1:0]   inflight;
    logic              quit_pend;
    logic              quit_at_end_q;
    logic              pre_q;
    logic              post_q;
    logic              busy_q;

    logic              in_loop;
    logic              in_run;
    logic              pipe_stall;
    logic              quit_seen;
    logic              issue;
    logic              last_issue;
    logic              quit_exit;
    logic              end_en;
    logic [IF_W-1:0]   inflight_next;

    always_comb begin
        in_loop    = (state == LOOP);
        in_run     = in_loop | (state == DRAIN);
        pipe_stall = stall & in_run;
        // A quit seen while stalled is parked in quit_pend and acts on the
        // first unstalled LOOP cycle, exactly like a live quit.
        quit_seen  = quit_pend | quit;
        issue      = in_loop & ~stall & (ii_cnt == '0) & (issued < trip_q) & ~quit_seen;
        last_issue = issue & (issued == trip_q - TRIP_W'(1));
        quit_exit  = in_loop & ~stall & quit_seen;

        inflight_next = inflight;
        if (issue & ~end_en) begin
            inflight_next = inflight + IF_W'(1);
        end else if (~issue & end_en) begin
            inflight_next = inflight - IF_W'(1);
        end
    end

    pp_valid_pipe #(
        .DEPTH (DEPTH)
    ) u_valid_pipe (
        .clock  (clock),
        .reset  (reset),
        .stall  (pipe_stall),
        .issue  (issue),
        .end_en (end_en)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            trip_q        <= '0;
            issued        <= '0;
            ii_cnt        <= '0;
            inflight      <= '0;
            quit_pend     <= 1'b0;
            quit_at_end_q <= 1'b0;
            pre_q         <= 1'b0;
            post_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            inflight <= inflight_next;
            if (issue) begin
                issued <= issued + TRIP_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= PRE;
                        trip_q        <= trip_count;
                        issued        <= '0;
                        quit_at_end_q <= 1'b0;
                        pre_q         <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                PRE: begin
                    pre_q     <= 1'b0;
                    ii_cnt    <= '0;
                    quit_pend <= 1'b0;
                    if (trip_q == '0) begin
                        state  <= POST;
                        post_q <= 1'b1;
                    end else begin
                        state <= LOOP;
                    end
                end
                LOOP: begin
                    if (stall) begin
                        if (quit) begin
                            quit_pend <= 1'b1;
                        end
                    end else begin
                        ii_cnt <= (ii_cnt == II_W'(II - 1)) ? '0 : ii_cnt + II_W'(1);
                        if (last_issue | quit_exit) begin
                            if (quit_exit && (issued < trip_q)) begin
                                quit_at_end_q <= 1'b1;
                            end
                            if (inflight_next == '0) begin
                                state  <= POST;
                                post_q <= 1'b1;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (!stall && (inflight_next == '0)) begin
                        state  <= POST;
                        post_q <= 1'b1;
                    end
                end
                POST: begin
                    state  <= IDLE;
                    post_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    pre_q  <= 1'b0;
                    post_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign cur_state         = FSM_WIDTH'(state);
    assign pre_states_valid  = pre_q;
    assign post_states_valid = post_q;
    assign finish            = post_q;
    assign busy              = busy_q;
    assign quit_at_end       = quit_at_end_q;
    assign iter_start_enable = issue;
    assign iter_index        = issue ? issued : '0;
    assign iter_end_enable   = end_en;

endmodule

// File: tb/tb_pp_loop_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pp_loop_ctrl
// Two controllers share one stimulus: dut0 (II=1, DEPTH=4, TRIP_W=16) and
// dut1 (II=3, DEPTH=2, TRIP_W=4). A reference model describes the loop as a
// schedule: an iteration may issue on every II-th unstalled LOOP cycle and
// retires DEPTH-1 unstalled cycles after it issued. Per-test event masks
// (bit n = test cycle n) are pinned against hand-worked cycle numbers.
// -----------------------------------------------------------------------------
module tb_pp_loop_ctrl;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        start;
  logic        stall;
  logic        quit;
  logic [15:0] trip_count;

  logic [2:0]  cs0, cs1;
  logic        pre0, pre1, post0, post1, ise0, ise1, iee0, iee1;
  logic        qae0, qae1, fin0, fin1, busy0, busy1;
  logic [15:0] idx0;
  logic [3:0]  idx1;

  pp_loop_ctrl #(.FSM_WIDTH(3), .II(1), .DEPTH(4), .TRIP_W(16)) u_dut0 (
    .clock(clock), .reset(reset), .start(start), .trip_count(trip_count),
    .stall(stall), .quit(quit), .cur_state(cs0), .pre_states_valid(pre0),
    .post_states_valid(post0), .iter_start_enable(ise0), .iter_index(idx0),
    .iter_end_enable(iee0), .quit_at_end(qae0), .finish(fin0), .busy(busy0)
  );

  pp_loop_ctrl #(.FSM_WIDTH(3), .II(3), .DEPTH(2), .TRIP_W(4)) u_dut1 (
    .clock(clock), .reset(reset), .start(start), .trip_count(trip_count[3:0]),
    .stall(stall), .quit(quit), .cur_state(cs1), .pre_states_valid(pre1),
    .post_states_valid(post1), .iter_start_enable(ise1), .iter_index(idx1),
    .iter_end_enable(iee1), .quit_at_end(qae1), .finish(fin1), .busy(busy1)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int tcyc     = 0;
  int log_sel  = 0;

  logic [63:0] st_mask, en_mask, fin_mask, drain_mask, pre_mask, busy_mask, qae_mask;

  // scoreboard of expected dut0 iteration indices
  logic [15:0] exp_q[$];

  // ---------------- reference model state ----------------
  int ii_of[2];
  int dep_of[2];
  int tmask[2];
  int m_state[2];
  int m_trip[2];
  int m_issued[2];
  int m_lcnt[2];
  int m_tick[2];
  int m_head[2];
  int m_tail[2];
  int m_max_if[2];
  bit m_ql[2];
  bit m_qae[2];
  int m_ret[2][64];

  task automatic chk(input string name, input int d, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc%0d: got %0h, expected %0h", name, d, tcyc, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  initial begin : compare_proc
    forever begin
      @(negedge clock);
      #2;
      for (int d = 0; d < 2; d++) begin
        int st, e_idx, a_st, a_idx;
        bit unst, qnow, e_iss, e_end;
        bit a_pre, a_post, a_ise, a_iee, a_qae, a_fin, a_busy;

        st    = m_state[d];
        unst  = ((st == 2) || (st == 3)) && !stall;
        qnow  = m_ql[d] || quit;
        e_iss = (st == 2) && !stall && ((m_lcnt[d] % ii_of[d]) == 0) &&
                (m_issued[d] < m_trip[d]) && !qnow;
        e_end = unst && (((m_head[d] < m_tail[d]) &&
                          (m_ret[d][m_head[d] % 64] == m_tick[d])) ||
                         (e_iss && (dep_of[d] == 1)));
        e_idx = e_iss ? m_issued[d] : 0;

        if (d == 0) begin
          a_st = int'(cs0); a_idx = int'(idx0); a_pre = pre0; a_post = post0;
          a_ise = ise0; a_iee = iee0; a_qae = qae0; a_fin = fin0; a_busy = busy0;
        end else begin
          a_st = int'(cs1); a_idx = int'(idx1); a_pre = pre1; a_post = post1;
          a_ise = ise1; a_iee = iee1; a_qae = qae1; a_fin = fin1; a_busy = busy1;
        end

        chk("state", d, a_st, st);
        chk("pre_valid", d, a_pre, (st == 1));
        chk("post_valid", d, a_post, (st == 4));
        chk("finish", d, a_fin, (st == 4));
        chk("busy", d, a_busy, (st != 0));
        chk("start_en", d, a_ise, e_iss);
        chk("iter_index", d, a_idx, e_idx);
        chk("end_en", d, a_iee, e_end);
        chk("quit_at_end", d, a_qae, m_qae[d]);

        if (d == 0) begin
          if (e_iss) exp_q.push_back(16'(e_idx));
          if (ise0) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL idx_sb dut0 cyc%0d: got index %0h, expected no issue", tcyc, idx0);
            end else begin
              chk("idx_sb", 0, idx0, exp_q.pop_front());
            end
          end
        end

        if ((d == log_sel) && (tcyc < 64)) begin
          if (e_iss)     st_mask[tcyc]    = 1'b1;
          if (e_end)     en_mask[tcyc]    = 1'b1;
          if (st == 4)   fin_mask[tcyc]   = 1'b1;
          if (st == 3)   drain_mask[tcyc] = 1'b1;
          if (st == 1)   pre_mask[tcyc]   = 1'b1;
          if (st != 0)   busy_mask[tcyc]  = 1'b1;
          if (m_qae[d])  qae_mask[tcyc]   = 1'b1;
        end

        // advance the model across the coming rising edge
        if (reset) begin
          m_state[d] = 0; m_issued[d] = 0; m_ql[d] = 1'b0; m_qae[d] = 1'b0;
          m_head[d] = 0; m_tail[d] = 0; m_lcnt[d] = 0;
        end else begin
          case (st)
            0: if (start) begin
              m_trip[d] = int'(trip_count) & tmask[d];
              m_issued[d] = 0; m_qae[d] = 1'b0; m_state[d] = 1;
            end
            1: begin
              m_lcnt[d] = 0; m_ql[d] = 1'b0; m_head[d] = 0; m_tail[d] = 0;
              m_state[d] = (m_trip[d] == 0) ? 4 : 2;
            end
            2: if (stall) begin
              if (quit) m_ql[d] = 1'b1;
            end else begin
              if (e_iss) begin
                m_ret[d][m_tail[d] % 64] = m_tick[d] + dep_of[d] - 1;
                m_tail[d]++;
                m_issued[d]++;
              end
              if (e_end) m_head[d]++;
              m_lcnt[d]++;
              m_tick[d]++;
              if (qnow || (e_iss && (m_issued[d] == m_trip[d]))) begin
                if (qnow && (m_issued[d] < m_trip[d])) m_qae[d] = 1'b1;
                m_state[d] = (m_head[d] == m_tail[d]) ? 4 : 3;
              end
            end
            3: if (!stall) begin
              if (e_end) m_head[d]++;
              m_tick[d]++;
              if (m_head[d] == m_tail[d]) m_state[d] = 4;
            end
            default: m_state[d] = 0;
          endcase
        end
        if ((m_tail[d] - m_head[d]) > m_max_if[d]) m_max_if[d] = m_tail[d] - m_head[d];
      end
    end
  end

  // ---------------- driver ----------------
  // Runs one loop: start on test cycle 0, stall over [s_lo, s_hi],
  // quit pulse at q_cyc, reset pulse at r_cyc (negative = none).
  task automatic run_test(input int trip, input int ncyc, input int s_lo, input int s_hi,
                          input int q_cyc, input int r_cyc, input int sel);
    log_sel = sel;
    st_mask = '0; en_mask = '0; fin_mask = '0; drain_mask = '0;
    pre_mask = '0; busy_mask = '0; qae_mask = '0;
    m_max_if[0] = 0;
    m_max_if[1] = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      tcyc       = c;
      start      = (c == 0);
      trip_count = trip[15:0];
      stall      = (c >= s_lo) && (c <= s_hi);
      quit       = (c == q_cyc);
      reset      = (c == r_cyc);
    end
    #4;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    ii_of[0] = 1; dep_of[0] = 4; tmask[0] = 32'hFFFF;
    ii_of[1] = 3; dep_of[1] = 2; tmask[1] = 32'hF;
    reset = 1'b1; start = 1'b0; stall = 1'b0; quit = 1'b0; trip_count = '0;

    repeat (2) @(negedge clock);
    #1;
    chk("rst_state", 0, cs0, 0);
    chk("rst_busy", 0, busy0, 0);
    chk("rst_finish", 0, fin0, 0);
    chk("rst_start_en", 0, ise0, 0);
    chk("rst_end_en", 0, iee0, 0);
    chk("rst_qae", 0, qae0, 0);
    chk("rst_state", 1, cs1, 0);
    chk("rst_busy", 1, busy1, 0);

    // basic run, II=1 DEPTH=4 trip=5
    run_test(5, 30, 99, 0, -1, -1, 0);
    chk("t1_pre", 0, pre_mask, 64'h2);
    chk("t1_starts", 0, st_mask, 64'h7C);
    chk("t1_ends", 0, en_mask, 64'h3E0);
    chk("t1_drain", 0, drain_mask, 64'h380);
    chk("t1_finish", 0, fin_mask, 64'h400);
    chk("t1_qae", 0, qae_mask, 64'h0);

    // II=3 DEPTH=2 trip=3
    run_test(3, 30, 99, 0, -1, -1, 1);
    chk("t2_starts", 1, st_mask, 64'h124);
    chk("t2_ends", 1, en_mask, 64'h248);
    chk("t2_drain", 1, drain_mask, 64'h200);
    chk("t2_finish", 1, fin_mask, 64'h400);
    chk("t2_max_inflight", 1, m_max_if[1], 1);

    // zero trip count
    run_test(0, 10, 99, 0, -1, -1, 0);
    chk("t3_pre", 0, pre_mask, 64'h2);
    chk("t3_finish", 0, fin_mask, 64'h4);
    chk("t3_starts", 0, st_mask, 64'h0);
    chk("t3_ends", 0, en_mask, 64'h0);

    // stall over cycles 3..4
    run_test(5, 30, 3, 4, -1, -1, 0);
    chk("t4_starts", 0, st_mask, 64'h1E4);
    chk("t4_ends", 0, en_mask, 64'hF80);
    chk("t4_finish", 0, fin_mask, 64'h1000);
    chk("t4_no_en_in_stall", 0, (st_mask | en_mask) & 64'h18, 64'h0);

    // quit pulse at cycle 4, trip=10
    run_test(10, 30, 99, 0, 4, -1, 0);
    chk("t5_starts", 0, st_mask, 64'hC);
    chk("t5_ends", 0, en_mask, 64'h60);
    chk("t5_finish", 0, fin_mask, 64'h80);
    chk("t5_qae", 0, qae_mask, 64'h3FFF_FFE0);

    // reset mid-loop at cycle 4; quit_at_end from the previous loop clears on start
    run_test(5, 12, 99, 0, -1, 4, 0);
    chk("t6_starts", 0, st_mask, 64'h1C);
    chk("t6_ends", 0, en_mask, 64'h0);
    chk("t6_finish", 0, fin_mask, 64'h0);
    chk("t6_busy", 0, busy_mask, 64'h1E);
    chk("t6_qae", 0, qae_mask, 64'h1);

    // clean run after the reset
    run_test(5, 30, 99, 0, -1, -1, 0);
    chk("t6b_starts", 0, st_mask, 64'h7C);
    chk("t6b_ends", 0, en_mask, 64'h3E0);
    chk("t6b_finish", 0, fin_mask, 64'h400);

    // quit arriving during a stall (stall 3..5, quit at 4)
    run_test(10, 30, 3, 5, 4, -1, 0);
    chk("t8_starts", 0, st_mask, 64'h4);
    chk("t8_ends", 0, en_mask, 64'h100);
    chk("t8_finish", 0, fin_mask, 64'h200);
    chk("t8_qae", 0, qae_mask, 64'h3FFF_FF80);

    // full-range trip on the 4-bit controller (trip = 15)
    run_test(15, 60, 99, 0, -1, -1, 1);
    chk("t7_issue_count", 1, $countones(st_mask), 15);
    chk("t7_end_count", 1, $countones(en_mask), 15);
    chk("t7_finish", 1, fin_mask, 64'h0000_4000_0000_0000);
    chk("t7_qae", 1, qae_mask, 64'h1);

    chk("sb_drained", 0, exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
